// File: rtl/rom_bus_arbiter_pkg.sv
// Shared types and helpers for the ROM/SRAM bus arbiter.
package rom_bus_arbiter_pkg;

  localparam int ADDR_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ_SNES = 2'd0,
    REQ_CX4  = 2'd1,
    REQ_MCU  = 2'd2,
    REQ_NONE = 2'd3
  } req_id_e;

  // Pick one byte out of a 16-bit chip word; hi_lane selects D[15:8].
  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic hi_lane);
    lane_byte = hi_lane ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/rom_bus_arbiter_req_latch.sv
// One requester's pending flag plus the request captured with it.
// A strobe that arrives while a request is already pending is ignored.
module rom_bus_arbiter_req_latch
  import rom_bus_arbiter_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [7:0]        wdata,
  input  logic              grant,
  output logic              pending,
  output logic [ADDR_W-1:0] cap_addr,
  output logic              cap_we,
  output logic [7:0]        cap_wdata
);

  // Grant clears the flag; a fresh strobe is captured only when nothing is pending.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending   <= 1'b0;
      cap_addr  <= {ADDR_W{1'b0}};
      cap_we    <= 1'b0;
      cap_wdata <= 8'h00;
    end else if (grant) begin
      pending <= 1'b0;
    end else if (req && !pending) begin
      pending   <= 1'b1;
      cap_addr  <= addr;
      cap_we    <= we;
      cap_wdata <= wdata;
    end
  end

endmodule

// File: rtl/rom_bus_arbiter.sv
// Time-multiplexes the external ROM/SRAM between SNES, Cx4 cache fill and MCU.
// Fixed priority SNES > Cx4 > MCU, with the MCU allowed through after a
// bounded run of Cx4 grants. Each access has a fixed cycle count.
module rom_bus_arbiter
  import rom_bus_arbiter_pkg::*;
#(
  parameter int RD_CYCLES = 6,
  parameter int WR_CYCLES = 6,
  parameter int CX4_BURST = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              snes_req,
  input  logic [ADDR_W-1:0] snes_addr,
  input  logic              snes_we,
  input  logic [7:0]        snes_wdata,
  output logic [7:0]        snes_rdata,
  output logic              snes_ack,
  input  logic              cx4_req,
  input  logic [ADDR_W-1:0] cx4_addr,
  output logic [15:0]       cx4_rdata,
  output logic              cx4_ack,
  input  logic              mcu_req,
  input  logic [ADDR_W-1:0] mcu_addr,
  input  logic              mcu_we,
  input  logic [7:0]        mcu_wdata,
  output logic [7:0]        mcu_rdata,
  output logic              mcu_ack,
  output logic [22:0]       ROM_ADDR,
  input  logic [15:0]       ROM_DATA_IN,
  output logic [15:0]       ROM_DATA_OUT,
  output logic              ROM_DOE,
  output logic              ROM_OE_N,
  output logic              ROM_WE_N,
  output logic              ROM_BHE_N,
  output logic              ROM_BLE_N,
  output logic              busy
);

  localparam int MAX_CYC  = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W    = $clog2(MAX_CYC + 1);
  localparam int STREAK_W = $clog2(CX4_BURST + 1) + 1;

  logic              snes_pend_s, cx4_pend_s, mcu_pend_s;
  logic [ADDR_W-1:0] snes_cap_addr_s, cx4_cap_addr_s, mcu_cap_addr_s;
  logic              snes_cap_we_s, cx4_cap_we_s, mcu_cap_we_s;
  logic [7:0]        snes_cap_wdata_s, cx4_cap_wdata_s, mcu_cap_wdata_s;
  logic              snes_gnt_s, cx4_gnt_s, mcu_gnt_s, gnt_any_s;

  arb_state_e        state_r, state_nx_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
  logic [STREAK_W-1:0] streak_r;
  req_id_e           win_s, acc_id_r;
  logic              acc_hi_r;
  logic [ADDR_W-1:0] win_addr_s;
  logic              win_we_s;
  logic [7:0]        win_wdata_s;
  logic              done_s, sample_s;

  rom_bus_arbiter_req_latch u_snes_latch (
    .CLK(CLK), .RST(RST), .req(snes_req), .addr(snes_addr), .we(snes_we),
    .wdata(snes_wdata), .grant(snes_gnt_s), .pending(snes_pend_s),
    .cap_addr(snes_cap_addr_s), .cap_we(snes_cap_we_s), .cap_wdata(snes_cap_wdata_s)
  );

  // Cx4 never writes, so its write inputs are tied off.
  rom_bus_arbiter_req_latch u_cx4_latch (
    .CLK(CLK), .RST(RST), .req(cx4_req), .addr(cx4_addr), .we(1'b0),
    .wdata(8'h00), .grant(cx4_gnt_s), .pending(cx4_pend_s),
    .cap_addr(cx4_cap_addr_s), .cap_we(cx4_cap_we_s), .cap_wdata(cx4_cap_wdata_s)
  );

  rom_bus_arbiter_req_latch u_mcu_latch (
    .CLK(CLK), .RST(RST), .req(mcu_req), .addr(mcu_addr), .we(mcu_we),
    .wdata(mcu_wdata), .grant(mcu_gnt_s), .pending(mcu_pend_s),
    .cap_addr(mcu_cap_addr_s), .cap_we(mcu_cap_we_s), .cap_wdata(mcu_cap_wdata_s)
  );

  // Fixed priority, except the MCU jumps ahead of Cx4 once the Cx4 run is used up.
  always_comb begin
    win_s = REQ_NONE;
    if (snes_pend_s) begin
      win_s = REQ_SNES;
    end else if (cx4_pend_s && !(mcu_pend_s && (streak_r == STREAK_W'(CX4_BURST)))) begin
      win_s = REQ_CX4;
    end else if (mcu_pend_s) begin
      win_s = REQ_MCU;
    end else begin
      win_s = REQ_NONE;
    end
  end

  // Select the captured request of the current winner.
  always_comb begin
    win_addr_s  = {ADDR_W{1'b0}};
    win_we_s    = 1'b0;
    win_wdata_s = 8'h00;
    case (win_s)
      REQ_SNES: begin
        win_addr_s  = snes_cap_addr_s;
        win_we_s    = snes_cap_we_s;
        win_wdata_s = snes_cap_wdata_s;
      end
      REQ_CX4: begin
        win_addr_s  = cx4_cap_addr_s;
        win_we_s    = cx4_cap_we_s;
        win_wdata_s = cx4_cap_wdata_s;
      end
      REQ_MCU: begin
        win_addr_s  = mcu_cap_addr_s;
        win_we_s    = mcu_cap_we_s;
        win_wdata_s = mcu_cap_wdata_s;
      end
      default: begin
        win_addr_s  = {ADDR_W{1'b0}};
        win_we_s    = 1'b0;
        win_wdata_s = 8'h00;
      end
    endcase
  end

  // Access sequencer: next state, cycle counter, grant pulses and completion.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    snes_gnt_s = 1'b0;
    cx4_gnt_s  = 1'b0;
    mcu_gnt_s  = 1'b0;
    done_s     = 1'b0;
    sample_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_s != REQ_NONE) begin
          snes_gnt_s = (win_s == REQ_SNES);
          cx4_gnt_s  = (win_s == REQ_CX4);
          mcu_gnt_s  = (win_s == REQ_MCU);
          if (win_we_s) begin
            state_nx_s = ST_WRITE;
            cnt_nx_s   = CNT_W'(WR_CYCLES - 2);
          end else begin
            state_nx_s = ST_READ;
            cnt_nx_s   = CNT_W'(RD_CYCLES - 1);
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nx_s = ST_IDLE;
          done_s     = 1'b1;
          sample_s   = 1'b1;
        end else begin
          cnt_nx_s = cnt_r - CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nx_s = ST_HOLD;
        end else begin
          cnt_nx_s = cnt_r - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        state_nx_s = ST_IDLE;
        done_s     = 1'b1;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  assign gnt_any_s = snes_gnt_s | cx4_gnt_s | mcu_gnt_s;

  // State register, access context and all registered pin/requester outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      acc_id_r     <= REQ_NONE;
      acc_hi_r     <= 1'b0;
      ROM_ADDR     <= 23'h0;
      ROM_DATA_OUT <= 16'h0000;
      ROM_DOE      <= 1'b0;
      ROM_OE_N     <= 1'b1;
      ROM_WE_N     <= 1'b1;
      ROM_BHE_N    <= 1'b1;
      ROM_BLE_N    <= 1'b1;
      busy         <= 1'b0;
      snes_ack     <= 1'b0;
      cx4_ack      <= 1'b0;
      mcu_ack      <= 1'b0;
      snes_rdata   <= 8'h00;
      cx4_rdata    <= 16'h0000;
      mcu_rdata    <= 8'h00;
    end else begin
      state_r  <= state_nx_s;
      cnt_r    <= cnt_nx_s;
      ROM_OE_N <= (state_nx_s != ST_READ);
      ROM_WE_N <= (state_nx_s != ST_WRITE);
      ROM_DOE  <= (state_nx_s == ST_WRITE) || (state_nx_s == ST_HOLD);
      busy     <= (state_nx_s != ST_IDLE);
      if (gnt_any_s) begin
        acc_id_r     <= win_s;
        acc_hi_r     <= win_addr_s[0];
        ROM_ADDR     <= win_addr_s[23:1];
        ROM_DATA_OUT <= {win_wdata_s, win_wdata_s};
        ROM_BHE_N    <= !((win_s == REQ_CX4) || win_addr_s[0]);
        ROM_BLE_N    <= !((win_s == REQ_CX4) || !win_addr_s[0]);
      end else if (state_nx_s == ST_IDLE) begin
        ROM_BHE_N <= 1'b1;
        ROM_BLE_N <= 1'b1;
      end
      snes_ack <= done_s && (acc_id_r == REQ_SNES);
      cx4_ack  <= done_s && (acc_id_r == REQ_CX4);
      mcu_ack  <= done_s && (acc_id_r == REQ_MCU);
      if (sample_s) begin
        case (acc_id_r)
          REQ_SNES: snes_rdata <= lane_byte(ROM_DATA_IN, acc_hi_r);
          REQ_CX4:  cx4_rdata  <= ROM_DATA_IN;
          REQ_MCU:  mcu_rdata  <= lane_byte(ROM_DATA_IN, acc_hi_r);
          default:  snes_rdata <= snes_rdata;
        endcase
      end
    end
  end

  // Count Cx4 grants made while the MCU waits; any MCU grant or idle MCU restarts it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      streak_r <= {STREAK_W{1'b0}};
    end else if (!mcu_pend_s || mcu_gnt_s) begin
      streak_r <= {STREAK_W{1'b0}};
    end else if (cx4_gnt_s && (streak_r != STREAK_W'(CX4_BURST))) begin
      streak_r <= streak_r + STREAK_W'(1);
    end
  end

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Self-checking bench for rom_bus_arbiter: directed scenarios plus random
// traffic, all compared against a timestamp-based transaction model.
module tb_rom_bus_arbiter;

  localparam int RD    = 6;
  localparam int WR    = 6;
  localparam int BURST = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        snes_req, snes_we, cx4_req, mcu_req, mcu_we;
  logic [23:0] snes_addr, cx4_addr, mcu_addr;
  logic [7:0]  snes_wdata, mcu_wdata, snes_rdata, mcu_rdata;
  logic [15:0] cx4_rdata, ROM_DATA_IN, ROM_DATA_OUT;
  logic        snes_ack, cx4_ack, mcu_ack;
  logic [22:0] ROM_ADDR;
  logic        ROM_DOE, ROM_OE_N, ROM_WE_N, ROM_BHE_N, ROM_BLE_N, busy;

  int checks_n   = 0;
  int failures_n = 0;

  always #5 CLK = ~CLK;

  rom_bus_arbiter #(.RD_CYCLES(RD), .WR_CYCLES(WR), .CX4_BURST(BURST)) dut (
    .CLK(CLK), .RST(RST),
    .snes_req(snes_req), .snes_addr(snes_addr), .snes_we(snes_we),
    .snes_wdata(snes_wdata), .snes_rdata(snes_rdata), .snes_ack(snes_ack),
    .cx4_req(cx4_req), .cx4_addr(cx4_addr), .cx4_rdata(cx4_rdata), .cx4_ack(cx4_ack),
    .mcu_req(mcu_req), .mcu_addr(mcu_addr), .mcu_we(mcu_we),
    .mcu_wdata(mcu_wdata), .mcu_rdata(mcu_rdata), .mcu_ack(mcu_ack),
    .ROM_ADDR(ROM_ADDR), .ROM_DATA_IN(ROM_DATA_IN), .ROM_DATA_OUT(ROM_DATA_OUT),
    .ROM_DOE(ROM_DOE), .ROM_OE_N(ROM_OE_N), .ROM_WE_N(ROM_WE_N),
    .ROM_BHE_N(ROM_BHE_N), .ROM_BLE_N(ROM_BLE_N), .busy(busy)
  );

  // ---------------- reference model (transaction + timestamps) -------------
  int          t_m;                // number of clock edges modelled so far
  bit          m_pend [3];
  logic [23:0] m_paddr[3];
  bit          m_pwe  [3];
  logic [7:0]  m_pwd  [3];
  bit          m_act;              // an access owns the bus
  int          m_id;
  logic [23:0] m_aaddr;
  bit          m_awe;
  logic [7:0]  m_awd;
  int          m_gnt_edge;
  int          m_streak;
  logic [22:0] e_addr;
  logic [7:0]  e_snes_rd, e_mcu_rd;
  logic [15:0] e_cx4_rd;
  bit          e_ack[3];

  int ack_ids[8];
  int ack_t[8];
  int ack_cnt;
  int oe_lo_n, we_lo_n;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      failures_n++;
      $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model across the next rising edge using the inputs now driven.
  task automatic model_step();
    int  e;
    int  w;
    bit  gnt[3];
    bit  rq[3];
    logic [23:0] ra[3];
    bit  rw[3];
    logic [7:0] rd[3];
    e = t_m + 1;
    rq = '{snes_req, cx4_req, mcu_req};
    ra = '{snes_addr, cx4_addr, mcu_addr};
    rw = '{snes_we, 1'b0, mcu_we};
    rd = '{snes_wdata, 8'h00, mcu_wdata};
    gnt = '{0, 0, 0};
    e_ack = '{0, 0, 0};
    if (RST) begin
      m_pend = '{0, 0, 0};
      m_act = 0; m_streak = 0;
      e_addr = 23'h0; e_snes_rd = 8'h00; e_mcu_rd = 8'h00; e_cx4_rd = 16'h0000;
    end else begin
      if (m_act) begin
        if (e == m_gnt_edge + (m_awe ? WR : RD)) begin
          m_act = 0;
          e_ack[m_id] = 1;
          if (!m_awe) begin
            if (m_id == 0) e_snes_rd = m_aaddr[0] ? ROM_DATA_IN[15:8] : ROM_DATA_IN[7:0];
            if (m_id == 1) e_cx4_rd  = ROM_DATA_IN;
            if (m_id == 2) e_mcu_rd  = m_aaddr[0] ? ROM_DATA_IN[15:8] : ROM_DATA_IN[7:0];
          end
        end
      end else begin
        w = -1;
        if (m_pend[0]) w = 0;
        else if (m_pend[1] && !(m_pend[2] && m_streak == BURST)) w = 1;
        else if (m_pend[2]) w = 2;
        if (w >= 0) begin
          gnt[w] = 1;
          m_act = 1; m_id = w; m_gnt_edge = e;
          m_aaddr = m_paddr[w]; m_awe = m_pwe[w]; m_awd = m_pwd[w];
          e_addr = m_paddr[w][23:1];
        end
      end
      if (!m_pend[2] || gnt[2]) m_streak = 0;
      else if (gnt[1]) m_streak++;
      for (int r = 0; r < 3; r++) begin
        if (gnt[r]) m_pend[r] = 0;
        else if (rq[r] && !m_pend[r]) begin
          m_pend[r] = 1; m_paddr[r] = ra[r]; m_pwe[r] = rw[r]; m_pwd[r] = rd[r];
        end
      end
    end
    t_m = e;
  endtask

  task automatic compare_outputs();
    int d;
    bit x_oe, x_we, x_doe, x_bhe, x_ble, x_busy;
    if (m_act) begin
      d = t_m - m_gnt_edge;
      x_busy = 1;
      x_oe   = m_awe;
      x_we   = !(m_awe && d < WR - 1);
      x_doe  = m_awe;
      x_bhe  = !(m_id == 1 || m_aaddr[0]);
      x_ble  = !(m_id == 1 || !m_aaddr[0]);
    end else begin
      x_busy = 0; x_oe = 1; x_we = 1; x_doe = 0; x_bhe = 1; x_ble = 1;
    end
    check_eq("oe_n", ROM_OE_N, x_oe);
    check_eq("we_n", ROM_WE_N, x_we);
    check_eq("doe", ROM_DOE, x_doe);
    check_eq("bhe_n", ROM_BHE_N, x_bhe);
    check_eq("ble_n", ROM_BLE_N, x_ble);
    check_eq("busy", busy, x_busy);
    check_eq("rom_addr", ROM_ADDR, e_addr);
    if (x_doe) check_eq("data_out", ROM_DATA_OUT, {m_awd, m_awd});
    check_eq("snes_ack", snes_ack, e_ack[0]);
    check_eq("cx4_ack", cx4_ack, e_ack[1]);
    check_eq("mcu_ack", mcu_ack, e_ack[2]);
    check_eq("snes_rdata", snes_rdata, e_snes_rd);
    check_eq("cx4_rdata", cx4_rdata, e_cx4_rd);
    check_eq("mcu_rdata", mcu_rdata, e_mcu_rd);
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    compare_outputs();
  endtask

  task automatic clear_strobes();
    snes_req = 1'b0; cx4_req = 1'b0; mcu_req = 1'b0; RST = 1'b0;
  endtask

  // Tick until the chosen requester acks; n = ticks taken, -1 on timeout.
  task automatic run_until_ack(input int which, input int budget, output int n);
    bit a;
    n = -1; oe_lo_n = 0; we_lo_n = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (!ROM_OE_N) oe_lo_n++;
      if (!ROM_WE_N) we_lo_n++;
      a = (which == 0) ? snes_ack : (which == 1) ? cx4_ack : mcu_ack;
      if (a) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic record_acks(input int n_ticks);
    ack_cnt = 0;
    for (int i = 1; i <= n_ticks; i++) begin
      tick();
      if (snes_ack && ack_cnt < 8) begin ack_ids[ack_cnt] = 0; ack_t[ack_cnt] = i; ack_cnt++; end
      if (cx4_ack  && ack_cnt < 8) begin ack_ids[ack_cnt] = 1; ack_t[ack_cnt] = i; ack_cnt++; end
      if (mcu_ack  && ack_cnt < 8) begin ack_ids[ack_cnt] = 2; ack_t[ack_cnt] = i; ack_cnt++; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [23:0] addr_a;
    t_m = 0; m_act = 0; m_streak = 0; m_pend = '{0, 0, 0};
    e_addr = 23'h0; e_snes_rd = 8'h00; e_mcu_rd = 8'h00; e_cx4_rd = 16'h0000;
    snes_addr = 24'h0; snes_we = 1'b0; snes_wdata = 8'h00;
    cx4_addr = 24'h0; mcu_addr = 24'h0; mcu_we = 1'b0; mcu_wdata = 8'h00;
    ROM_DATA_IN = 16'h0000;
    clear_strobes();
    RST = 1'b1;
    tick();
    tick();
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_oe_n", ROM_OE_N, 1'b1);
    RST = 1'b0;
    tick();

    // SNES byte read from the high lane
    ROM_DATA_IN = 16'hA55A;
    snes_req = 1'b1; snes_addr = 24'h000101; snes_we = 1'b0;
    tick();
    clear_strobes();
    run_until_ack(0, 20, n);
    check_eq("snes_rd_latency", n, 7);
    check_eq("snes_rd_oe_cycles", oe_lo_n, 6);
    check_eq("snes_rd_data", snes_rdata, 8'hA5);
    check_eq("snes_rd_addr", ROM_ADDR, 23'h000080);
    tick();

    // MCU byte write to the low lane
    mcu_req = 1'b1; mcu_addr = 24'hE00000; mcu_we = 1'b1; mcu_wdata = 8'h3C;
    tick();
    clear_strobes();
    run_until_ack(2, 20, n);
    check_eq("mcu_wr_latency", n, 7);
    check_eq("mcu_wr_we_cycles", we_lo_n, 5);
    check_eq("mcu_wr_addr", ROM_ADDR, 23'h700000);
    tick();

    // All three strobe together
    snes_req = 1'b1; snes_addr = 24'h012345; snes_we = 1'b0;
    cx4_req = 1'b1; cx4_addr = 24'h0ABCDF;
    mcu_req = 1'b1; mcu_addr = 24'h3F0002; mcu_we = 1'b0;
    ROM_DATA_IN = 16'h1234;
    tick();
    clear_strobes();
    record_acks(30);
    check_eq("tri_ack_count", ack_cnt, 3);
    check_eq("tri_order0", ack_ids[0], 0);
    check_eq("tri_order1", ack_ids[1], 1);
    check_eq("tri_order2", ack_ids[2], 2);
    check_eq("tri_gap1", ack_t[1] - ack_t[0], 7);
    check_eq("tri_gap2", ack_t[2] - ack_t[1], 7);

    // Cx4 keeps re-requesting while the MCU waits
    cx4_req = 1'b1; cx4_addr = 24'h100000;
    mcu_req = 1'b1; mcu_addr = 24'h200001; mcu_we = 1'b0;
    tick();
    mcu_req = 1'b0;
    record_acks(24);
    check_eq("streak_ack_count", ack_cnt, 3);
    check_eq("streak_order0", ack_ids[0], 1);
    check_eq("streak_order1", ack_ids[1], 1);
    check_eq("streak_order2", ack_ids[2], 2);
    clear_strobes();
    for (int i = 0; i < 20; i++) tick();

    // Second SNES strobe while the first is still pending is dropped
    addr_a = 24'h123457;
    snes_req = 1'b1; snes_addr = addr_a; snes_we = 1'b0;
    tick();
    snes_addr = 24'h00ABCD;
    tick();
    clear_strobes();
    record_acks(15);
    check_eq("dup_ack_count", ack_cnt, 1);
    check_eq("dup_addr", ROM_ADDR, addr_a[23:1]);

    // Reset during the third write cycle aborts the access
    mcu_req = 1'b1; mcu_addr = 24'hE00000; mcu_we = 1'b1; mcu_wdata = 8'h3C;
    tick();
    clear_strobes();
    tick(); tick(); tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_eq("rst_we_n", ROM_WE_N, 1'b1);
    check_eq("rst_doe", ROM_DOE, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_no_ack", mcu_ack, 1'b0);
    record_acks(10);
    check_eq("rst_ack_count", ack_cnt, 0);
    ROM_DATA_IN = 16'h9966;
    snes_req = 1'b1; snes_addr = 24'h000010; snes_we = 1'b0;
    tick();
    clear_strobes();
    run_until_ack(0, 20, n);
    check_eq("post_rst_latency", n, 7);
    check_eq("post_rst_data", snes_rdata, 8'h66);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      snes_req   = ($urandom_range(0, 7) == 0);
      snes_addr  = 24'($urandom);
      snes_we    = $urandom_range(0, 1) == 1;
      snes_wdata = 8'($urandom);
      cx4_req    = ($urandom_range(0, 5) == 0);
      cx4_addr   = 24'($urandom);
      mcu_req    = ($urandom_range(0, 5) == 0);
      mcu_addr   = 24'($urandom);
      mcu_we     = $urandom_range(0, 1) == 1;
      mcu_wdata  = 8'($urandom);
      ROM_DATA_IN = 16'($urandom);
      RST        = ($urandom_range(0, 299) == 0);
      tick();
    end
    clear_strobes();
    for (int i = 0; i < 40; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, failures_n);
    $finish;
  end

endmodule
